led_seq_multi: RTL

//  Multi-channel LED colour sequencer, generalising the single-channel button-stepped colour cycler.

---
 rtl/led_pkg.sv | 32 +++
 rtl/led_btn_debounce.sv | 95 +++++++++
 rtl/led_seq_multi.sv | 86 ++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and colour-step helpers for the multi-channel LED sequencer.
// Helpers work on plain integers so every instance can use its own code width.
package led_pkg;

    typedef enum logic [1:0] {
        DB_IDLE    = 2'd0,
        DB_PRESS   = 2'd1,
        DB_HELD    = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

    // Upward step with wrap from the top of the legal range back to its bottom.
    function automatic int unsigned next_up(input int unsigned c,
                                            input int unsigned lo,
                                            input int unsigned hi);
        return (c == hi) ? lo : c + 1;
    endfunction

    function automatic int unsigned next_down(input int unsigned c,
                                              input int unsigned lo,
                                              input int unsigned hi);
        return (c == lo) ? hi : c - 1;
    endfunction

    function automatic logic step_wraps(input logic        up,
                                        input int unsigned c,
                                        input int unsigned lo,
                                        input int unsigned hi);
        return up ? (c == hi) : (c == lo);
    endfunction

endpackage

// File: rtl/led_btn_debounce.sv
// Per-channel button debouncer: emits one registered step pulse per accepted press,
// and needs a run of DEBOUNCE identical samples to accept either a press or a release.
module led_btn_debounce
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic step
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    // cnt counts the samples seen so far in the current run; DEBOUNCE==1 skips the counting states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        unique case (state_q)
            DB_IDLE: begin
                if (button) begin
                    if (DEBOUNCE == 1) begin
                        state_d = DB_HELD;
                        cnt_d   = '0;
                        step_d  = 1'b1;
                    end else begin
                        state_d = DB_PRESS;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            DB_PRESS: begin
                if (!button) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DB_HELD: begin
                if (!button) begin
                    if (DEBOUNCE == 1) begin
                        state_d = DB_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = DB_RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            DB_RELEASE: begin
                // A bounce back high returns to HELD silently: the press was already counted.
                if (button) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign step = step_q;

endmodule

// File: rtl/led_seq_multi.sv
// Multi-channel LED colour sequencer: each channel cycles MIN_VAL..MAX_VAL on its own
// debounced button, and in auto mode all channels also step together on a prescaled tick.
module led_seq_multi
    import led_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MIN_VAL  = 1,
    parameter int unsigned MAX_VAL  = 6,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned AUTO_DIV = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       button,
    input  logic                      dir,
    input  logic                      mode,
    output logic [CHANNELS*WIDTH-1:0] colour,
    output logic [CHANNELS-1:0]       wrap
);

    localparam int unsigned PRE_W = $clog2(AUTO_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

    logic [PRE_W-1:0]    pre_q;
    logic                tick;
    logic [CHANNELS-1:0] step;

    // Prescaler is parked at 0 in manual mode so the first auto tick lands AUTO_DIV edges after mode rises.
    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst || !mode) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [WIDTH-1:0] col_q, col_d;
        logic             wrap_q, wrap_d;
        logic             adv;

        led_btn_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .button(button[n]),
            .step  (step[n])
        );

        // OR-ing the two sources makes a button step coinciding with a tick a single advance.
        assign adv = step[n] | (mode & tick);

        always_comb begin
            col_d  = col_q;
            wrap_d = 1'b0;
            if (adv) begin
                wrap_d = step_wraps(dir, 32'(col_q), MIN_VAL, MAX_VAL);
                if (dir) begin
                    col_d = WIDTH'(next_up(32'(col_q), MIN_VAL, MAX_VAL));
                end else begin
                    col_d = WIDTH'(next_down(32'(col_q), MIN_VAL, MAX_VAL));
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                col_q  <= WIDTH'(MIN_VAL);
                wrap_q <= 1'b0;
            end else begin
                col_q  <= col_d;
                wrap_q <= wrap_d;
            end
        end

        assign colour[n*WIDTH +: WIDTH] = col_q;
        assign wrap[n]                  = wrap_q;
    end

endmodule
